// File: rtl/main_control_unit_if.sv
// rtl/main_control_unit_if.sv - controller-to-datapath signal bundle for the multi-cycle MIPS control unit
interface main_control_unit_if #(
    parameter int OPCODE_W = 6,
    parameter int FUNCT_W  = 6
);
    logic [OPCODE_W-1:0] Opcode;
    logic [FUNCT_W-1:0]  Funct;
    logic                Zero_Flag;
    logic                Overflow_Flag;
    logic [3:0]          ALU_Cntrl;
    logic                ALUSrcA;
    logic [1:0]          ALUSrcB;
    logic [1:0]          PCSrc;
    logic                PC_En;
    logic                IorD;
    logic                MemWrite;
    logic                IRWrite;
    logic                RegDst;
    logic                MemtoReg;
    logic                RegWrite;
    logic                Exception;

    // The controller is the master: it consumes IR fields and ALU flags, drives every datapath control.
    modport master (
        input  Opcode, Funct, Zero_Flag, Overflow_Flag,
        output ALU_Cntrl, ALUSrcA, ALUSrcB, PCSrc, PC_En, IorD, MemWrite,
               IRWrite, RegDst, MemtoReg, RegWrite, Exception
    );

    modport slave (
        output Opcode, Funct, Zero_Flag, Overflow_Flag,
        input  ALU_Cntrl, ALUSrcA, ALUSrcB, PCSrc, PC_En, IorD, MemWrite,
               IRWrite, RegDst, MemtoReg, RegWrite, Exception
    );
endinterface

// File: rtl/main_control_unit.sv
// rtl/main_control_unit.sv - Moore FSM sequencing fetch/decode/execute/memory/writeback for the MIPS datapath
module main_control_unit #(
    parameter int OPCODE_W = 6,
    parameter int FUNCT_W  = 6
) (
    input logic CLK,
    input logic RST,
    main_control_unit_if.master bus
);
    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
        JUMP   = 4'd11,
        TRAP   = 4'd12
    } state_t;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'(6'b000000);
    localparam logic [OPCODE_W-1:0] OP_J     = OPCODE_W'(6'b000010);
    localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(6'b000100);
    localparam logic [OPCODE_W-1:0] OP_BNE   = OPCODE_W'(6'b000101);
    localparam logic [OPCODE_W-1:0] OP_ADDI  = OPCODE_W'(6'b001000);
    localparam logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'(6'b100011);
    localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'(6'b101011);

    localparam logic [FUNCT_W-1:0] FN_ADD = FUNCT_W'(6'b100000);
    localparam logic [FUNCT_W-1:0] FN_SUB = FUNCT_W'(6'b100010);

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_NOR  = 4'b0100;
    localparam logic [3:0] ALU_SLTU = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLL  = 4'b1000;
    localparam logic [3:0] ALU_SLLV = 4'b1001;
    localparam logic [3:0] ALU_SRL  = 4'b1010;
    localparam logic [3:0] ALU_SRLV = 4'b1011;
    localparam logic [3:0] ALU_SRA  = 4'b1100;
    localparam logic [3:0] ALU_SRAV = 4'b1101;

    state_t     state;
    state_t     state_next;
    logic       rt_valid;
    logic [3:0] rt_cntrl;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    // R-type funct decode, shared by the DECODE legality check and the EXEC ALU code.
    always_comb begin
        rt_valid = 1'b1;
        rt_cntrl = ALU_AND;
        case (bus.Funct)
            FUNCT_W'(6'b100000): rt_cntrl = ALU_ADD;
            FUNCT_W'(6'b100001): rt_cntrl = ALU_ADD;
            FUNCT_W'(6'b100010): rt_cntrl = ALU_SUB;
            FUNCT_W'(6'b100011): rt_cntrl = ALU_SUB;
            FUNCT_W'(6'b100100): rt_cntrl = ALU_AND;
            FUNCT_W'(6'b100101): rt_cntrl = ALU_OR;
            FUNCT_W'(6'b100110): rt_cntrl = ALU_XOR;
            FUNCT_W'(6'b100111): rt_cntrl = ALU_NOR;
            FUNCT_W'(6'b101010): rt_cntrl = ALU_SLT;
            FUNCT_W'(6'b101011): rt_cntrl = ALU_SLTU;
            FUNCT_W'(6'b000000): rt_cntrl = ALU_SLL;
            FUNCT_W'(6'b000010): rt_cntrl = ALU_SRL;
            FUNCT_W'(6'b000011): rt_cntrl = ALU_SRA;
            FUNCT_W'(6'b000100): rt_cntrl = ALU_SLLV;
            FUNCT_W'(6'b000110): rt_cntrl = ALU_SRLV;
            FUNCT_W'(6'b000111): rt_cntrl = ALU_SRAV;
            default:             rt_valid = 1'b0;
        endcase
    end

    always_comb begin
        state_next        = FETCH;
        bus.ALU_Cntrl     = ALU_AND;
        bus.ALUSrcA       = 1'b0;
        bus.ALUSrcB       = 2'b00;
        bus.PCSrc         = 2'b00;
        bus.PC_En         = 1'b0;
        bus.IorD          = 1'b0;
        bus.MemWrite      = 1'b0;
        bus.IRWrite       = 1'b0;
        bus.RegDst        = 1'b0;
        bus.MemtoReg      = 1'b0;
        bus.RegWrite      = 1'b0;
        bus.Exception     = 1'b0;

        case (state)
            FETCH: begin
                bus.ALUSrcB   = 2'b01;
                bus.ALU_Cntrl = ALU_ADD;
                bus.IRWrite   = 1'b1;
                bus.PC_En     = 1'b1;
                state_next    = DECODE;
            end
            DECODE: begin
                bus.ALUSrcB   = 2'b11;
                bus.ALU_Cntrl = ALU_ADD;
                if (bus.Opcode == OP_LW || bus.Opcode == OP_SW) begin
                    state_next = MEMADR;
                end else if (bus.Opcode == OP_RTYPE) begin
                    state_next = rt_valid ? EXEC : TRAP;
                end else if (bus.Opcode == OP_BEQ || bus.Opcode == OP_BNE) begin
                    state_next = BRANCH;
                end else if (bus.Opcode == OP_ADDI) begin
                    state_next = ADDIEX;
                end else if (bus.Opcode == OP_J) begin
                    state_next = JUMP;
                end else begin
                    state_next = TRAP;
                end
            end
            MEMADR: begin
                bus.ALUSrcA   = 1'b1;
                bus.ALUSrcB   = 2'b10;
                bus.ALU_Cntrl = ALU_ADD;
                state_next    = (bus.Opcode == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                bus.IorD   = 1'b1;
                state_next = MEMWB;
            end
            MEMWB: begin
                bus.MemtoReg = 1'b1;
                bus.RegWrite = 1'b1;
            end
            MEMWR: begin
                bus.IorD     = 1'b1;
                bus.MemWrite = 1'b1;
            end
            EXEC: begin
                bus.ALUSrcA   = 1'b1;
                bus.ALU_Cntrl = rt_cntrl;
                // Only the signed add/sub trap; the unsigned variants share the ALU code but ignore overflow.
                if ((bus.Funct == FN_ADD || bus.Funct == FN_SUB) && bus.Overflow_Flag) begin
                    state_next = TRAP;
                end else begin
                    state_next = ALUWB;
                end
            end
            ALUWB: begin
                bus.RegDst   = 1'b1;
                bus.RegWrite = 1'b1;
            end
            BRANCH: begin
                bus.ALUSrcA   = 1'b1;
                bus.ALU_Cntrl = ALU_SUB;
                bus.PCSrc     = 2'b01;
                if (bus.Opcode == OP_BEQ) begin
                    bus.PC_En = bus.Zero_Flag;
                end else if (bus.Opcode == OP_BNE) begin
                    bus.PC_En = ~bus.Zero_Flag;
                end
            end
            ADDIEX: begin
                bus.ALUSrcA   = 1'b1;
                bus.ALUSrcB   = 2'b10;
                bus.ALU_Cntrl = ALU_ADD;
                state_next    = bus.Overflow_Flag ? TRAP : ADDIWB;
            end
            ADDIWB: begin
                bus.RegWrite = 1'b1;
            end
            JUMP: begin
                bus.PCSrc = 2'b10;
                bus.PC_En = 1'b1;
            end
            TRAP: begin
                bus.Exception = 1'b1;
            end
            default: begin
                state_next = FETCH;
            end
        endcase

        // Reset overrides the state decode so nothing is written while the machine is held.
        if (RST) begin
            bus.ALU_Cntrl = 4'b0000;
            bus.ALUSrcA   = 1'b0;
            bus.ALUSrcB   = 2'b00;
            bus.PCSrc     = 2'b00;
            bus.PC_En     = 1'b0;
            bus.IorD      = 1'b0;
            bus.MemWrite  = 1'b0;
            bus.IRWrite   = 1'b0;
            bus.RegDst    = 1'b0;
            bus.MemtoReg  = 1'b0;
            bus.RegWrite  = 1'b0;
            bus.Exception = 1'b0;
        end
    end
endmodule

// File: tb/tb_main_control_unit.sv
// tb/tb_main_control_unit.sv - randomized self-checking bench for main_control_unit against an instruction-level model
module tb_main_control_unit;
    logic CLK;
    logic RST;
    int   checks;
    int   errors;

    main_control_unit_if #(.OPCODE_W(6), .FUNCT_W(6)) bus ();

    main_control_unit #(.OPCODE_W(6), .FUNCT_W(6)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.master)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    logic [16:0] exp_q[$];
    logic [5:0]  fn_list [16] = '{6'b100000, 6'b100001, 6'b100010, 6'b100011,
                                  6'b100100, 6'b100101, 6'b100110, 6'b100111,
                                  6'b101010, 6'b101011, 6'b000000, 6'b000010,
                                  6'b000011, 6'b000100, 6'b000110, 6'b000111};
    logic [5:0]  op_list [7]  = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                                  6'b000101, 6'b001000, 6'b000010};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [16:0] obs();
        return {bus.ALU_Cntrl, bus.ALUSrcA, bus.ALUSrcB, bus.PCSrc, bus.PC_En, bus.IorD,
                bus.MemWrite, bus.IRWrite, bus.RegDst, bus.MemtoReg, bus.RegWrite, bus.Exception};
    endfunction

    function automatic logic [16:0] cw(input logic [3:0] alu, input logic srca, input logic [1:0] srcb,
                                       input logic [1:0] pcsrc, input logic pcen, input logic iord,
                                       input logic memw, input logic irw, input logic regdst,
                                       input logic m2r, input logic regw, input logic exc);
        return {alu, srca, srcb, pcsrc, pcen, iord, memw, irw, regdst, m2r, regw, exc};
    endfunction

    // ALU code an R-type funct should produce; -1 marks an illegal funct.
    function automatic int rfn(input logic [5:0] fn);
        case (fn)
            6'b100000, 6'b100001: return 2;
            6'b100010, 6'b100011: return 6;
            6'b100100: return 0;
            6'b100101: return 1;
            6'b100110: return 3;
            6'b100111: return 4;
            6'b101010: return 7;
            6'b101011: return 5;
            6'b000000: return 8;
            6'b000010: return 10;
            6'b000011: return 12;
            6'b000100: return 9;
            6'b000110: return 11;
            6'b000111: return 13;
            default:   return -1;
        endcase
    endfunction

    // Expected per-cycle control words for one instruction, FETCH through its last state.
    function automatic void build(input logic [5:0] op, input logic [5:0] fn, input logic z, input logic o);
        logic [16:0] trap_w;
        int a;
        trap_w = cw(4'd0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1);
        exp_q = {};
        exp_q.push_back(cw(4'd2, 0, 2'b01, 2'b00, 1, 0, 0, 1, 0, 0, 0, 0));
        exp_q.push_back(cw(4'd2, 0, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
        case (op)
            6'b100011: begin
                exp_q.push_back(cw(4'd2, 1, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
                exp_q.push_back(cw(4'd0, 0, 2'b00, 2'b00, 0, 1, 0, 0, 0, 0, 0, 0));
                exp_q.push_back(cw(4'd0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 1, 0));
            end
            6'b101011: begin
                exp_q.push_back(cw(4'd2, 1, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
                exp_q.push_back(cw(4'd0, 0, 2'b00, 2'b00, 0, 1, 1, 0, 0, 0, 0, 0));
            end
            6'b000000: begin
                a = rfn(fn);
                if (a < 0) begin
                    exp_q.push_back(trap_w);
                end else begin
                    exp_q.push_back(cw(4'(a), 1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
                    if ((fn == 6'b100000 || fn == 6'b100010) && o)
                        exp_q.push_back(trap_w);
                    else
                        exp_q.push_back(cw(4'd0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 1, 0, 1, 0));
                end
            end
            6'b000100: exp_q.push_back(cw(4'd6, 1, 2'b00, 2'b01, z, 0, 0, 0, 0, 0, 0, 0));
            6'b000101: exp_q.push_back(cw(4'd6, 1, 2'b00, 2'b01, ~z, 0, 0, 0, 0, 0, 0, 0));
            6'b001000: begin
                exp_q.push_back(cw(4'd2, 1, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
                if (o) exp_q.push_back(trap_w);
                else   exp_q.push_back(cw(4'd0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0));
            end
            6'b000010: exp_q.push_back(cw(4'd0, 0, 2'b00, 2'b10, 1, 0, 0, 0, 0, 0, 0, 0));
            default:   exp_q.push_back(trap_w);
        endcase
    endfunction

    // Called just after a rising edge that left the DUT in FETCH; returns at the same point for the next one.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z, input logic o,
                             input int abort_at);
        build(op, fn, z, o);
        bus.Opcode        = 6'($urandom);
        bus.Funct         = 6'($urandom);
        bus.Zero_Flag     = 1'($urandom);
        bus.Overflow_Flag = 1'($urandom);
        #1;
        check($sformatf("op%b_fn%b_z%0d_o%0d_c0", op, fn, z, o), 32'(obs()), 32'(exp_q[0]));
        bus.Opcode        = op;
        bus.Funct         = fn;
        bus.Zero_Flag     = z;
        bus.Overflow_Flag = o;
        for (int i = 1; i < exp_q.size(); i++) begin
            @(posedge CLK);
            #1;
            check($sformatf("op%b_fn%b_z%0d_o%0d_c%0d", op, fn, z, o, i), 32'(obs()), 32'(exp_q[i]));
            if (i == abort_at) begin
                RST = 1'b1;
                @(posedge CLK);
                #1;
                check("reset_abort_outputs", 32'(obs()), 32'd0);
                RST = 1'b0;
                return;
            end
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        RST    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.Opcode        = 6'($urandom);
            bus.Funct         = 6'($urandom);
            bus.Zero_Flag     = 1'($urandom);
            bus.Overflow_Flag = 1'($urandom);
            @(posedge CLK);
            #1;
            check($sformatf("reset_hold_%0d", i), 32'(obs()), 32'd0);
        end
        RST = 1'b0;

        run_instr(6'b100011, 6'($urandom), 1'b0, 1'b0, -1);
        run_instr(6'b101011, 6'($urandom), 1'b1, 1'b1, -1);
        for (int i = 0; i < 16; i++) run_instr(6'b000000, fn_list[i], 1'($urandom), 1'b0, -1);
        run_instr(6'b000000, 6'b011000, 1'b0, 1'b0, -1);
        run_instr(6'b000000, 6'b100000, 1'b0, 1'b1, -1);
        run_instr(6'b000000, 6'b100001, 1'b0, 1'b1, -1);
        run_instr(6'b000000, 6'b100010, 1'b0, 1'b1, -1);
        run_instr(6'b000000, 6'b100011, 1'b0, 1'b1, -1);
        run_instr(6'b001000, 6'($urandom), 1'b0, 1'b1, -1);
        run_instr(6'b001000, 6'($urandom), 1'b0, 1'b0, -1);
        run_instr(6'b000100, 6'($urandom), 1'b1, 1'b0, -1);
        run_instr(6'b000100, 6'($urandom), 1'b0, 1'b0, -1);
        run_instr(6'b000101, 6'($urandom), 1'b1, 1'b0, -1);
        run_instr(6'b000101, 6'($urandom), 1'b0, 1'b0, -1);
        run_instr(6'b000010, 6'($urandom), 1'b0, 1'b0, -1);
        run_instr(6'b111111, 6'($urandom), 1'b0, 1'b0, -1);
        run_instr(6'b100011, 6'($urandom), 1'b0, 1'b0, 3);
        run_instr(6'b100011, 6'($urandom), 1'b0, 1'b0, -1);

        for (int n = 0; n < 300; n++) begin
            logic [5:0] op;
            logic [5:0] fn;
            op = ($urandom_range(0, 4) == 0) ? 6'($urandom) : op_list[$urandom_range(0, 6)];
            fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fn_list[$urandom_range(0, 15)];
            run_instr(op, fn, 1'($urandom), 1'($urandom), ($urandom_range(0, 19) == 0) ? 2 : -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
